// File: rtl/serdes_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_cfg_pkg
// Description : Shared register offsets, field positions and sequencer state
//               encoding for the SerDes configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_OSC_ON   = 3'd2,
        ST_AUX_ON   = 3'd3,
        ST_INJ_ON   = 3'd4,
        ST_FFTL_ON  = 3'd5,
        ST_RUN      = 3'd6
    } seq_state_e;

    localparam logic [7:0] C_OFF_CTRL   = 8'h00;
    localparam logic [7:0] C_OFF_STATUS = 8'h04;
    localparam logic [7:0] C_OFF_DLY    = 8'h08;
    localparam logic [7:0] C_OFF_CFG0   = 8'h0C;
    localparam logic [7:0] C_OFF_CFG1   = 8'h10;
    localparam logic [7:0] C_OFF_PI     = 8'h14;
    localparam logic [7:0] C_OFF_TEST   = 8'h18;

    localparam int C_CTRL_START_BIT  = 0;
    localparam int C_CTRL_ABORT_BIT  = 1;
    localparam int C_CTRL_INJ_BIT    = 2;
    localparam int C_STATUS_BLK_BIT  = 4;

    localparam int C_CFG0_DIV_LSB   = 0;
    localparam int C_CFG0_DIV_W     = 6;
    localparam int C_CFG0_AVG_LSB   = 6;
    localparam int C_CFG0_AVG_W     = 5;
    localparam int C_CFG0_STEP_LSB  = 11;
    localparam int C_CFG0_STEP_W    = 4;
    localparam int C_CFG0_PERB_LSB  = 15;
    localparam int C_CFG0_PERB_W    = 4;

    localparam int C_TEST_MUX_LSB   = 0;
    localparam int C_TEST_MUX_W     = 4;
    localparam int C_TEST_CLKI_LSB  = 4;
    localparam int C_TEST_CLKI_W    = 2;
    localparam int C_TEST_CLKQ_LSB  = 6;
    localparam int C_TEST_CLKQ_W    = 2;
    localparam int C_TEST_BUFN_LSB  = 8;
    localparam int C_TEST_BUFN_W    = 6;
    localparam int C_TEST_BUFP_LSB  = 14;
    localparam int C_TEST_BUFP_W    = 6;

    localparam logic [31:0] C_MASK_DLY  = 32'h0000_FFFF;
    localparam logic [31:0] C_MASK_CFG0 = 32'h0007_FFFF;
    localparam logic [31:0] C_MASK_CFG1 = 32'h0000_1FFF;
    localparam logic [31:0] C_MASK_PI   = 32'h000F_FFFF;
    localparam logic [31:0] C_MASK_TEST = 32'h000F_FFFF;

    // Byte-lane merge of write data into the old value, masked to the register width.
    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel,
                                             input logic [31:0] mask);
        logic [31:0] w_res;
        w_res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                w_res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return w_res & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module      : serdes_seq_fsm
// Description : Bring-up sequencer: state register, per-step dwell counter and
//               registered decode of core reset, enables and PRBS reset.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_seq_fsm
    import serdes_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_dly,
    output seq_state_e  o_state,
    output logic        o_core_rst,
    output logic        o_rst_prbs,
    output logic        o_osc_en,
    output logic        o_aux_osc_en,
    output logic        o_inj_en,
    output logic        o_fftl_en,
    output logic        o_seq_irq
);

    seq_state_e  r_state;
    seq_state_e  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_dwell;

    // A zero dwell still spends one cycle in each step.
    assign w_dwell = (i_dly == 16'd0) ? 16'd1 : i_dly;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else if (i_start) begin
            w_state_nxt = ST_RST_HOLD;
            w_cnt_nxt   = w_dwell;
        end else begin
            case (r_state)
                ST_RST_HOLD, ST_OSC_ON, ST_AUX_ON, ST_INJ_ON, ST_FFTL_ON: begin
                    if (r_cnt <= 16'd1) begin
                        w_state_nxt = seq_state_e'(r_state + 3'd1);
                        w_cnt_nxt   = w_dwell;
                    end else begin
                        w_cnt_nxt   = r_cnt - 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change in step with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd1;
            o_core_rst   <= 1'b1;
            o_rst_prbs   <= 1'b1;
            o_osc_en     <= 1'b0;
            o_aux_osc_en <= 1'b0;
            o_inj_en     <= 1'b0;
            o_fftl_en    <= 1'b0;
            o_seq_irq    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            o_core_rst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RST_HOLD);
            o_rst_prbs   <= (w_state_nxt != ST_RUN);
            o_osc_en     <= (w_state_nxt >= ST_OSC_ON);
            o_aux_osc_en <= (w_state_nxt >= ST_AUX_ON);
            o_inj_en     <= (w_state_nxt >= ST_INJ_ON);
            o_fftl_en    <= (w_state_nxt >= ST_FFTL_ON);
            o_seq_irq    <= (r_state == ST_FFTL_ON) && (w_state_nxt == ST_RUN);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/serdes_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serdes_cfg_sequencer
// Description : Wishbone-slave config register bank and bring-up sequencer
//               for the SerDes / injection-locked-oscillator core.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_cfg_sequencer
    import serdes_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [15:0] DLY_DEFAULT = 16'd1024
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_rst,
    output logic        rst_prbs,
    output logic        osc_en,
    output logic        aux_osc_en,
    output logic        inj_en,
    output logic        fftl_en,
    output logic        inj_error,
    output logic [5:0]  div_ratio_half,
    output logic [4:0]  avg_window,
    output logic [3:0]  step_size,
    output logic [3:0]  con_perb,
    output logic [12:0] manual_control_osc,
    output logic [19:0] pi_con,
    output logic [3:0]  test_mux_select,
    output logic [1:0]  clk_I_select,
    output logic [1:0]  clk_Q_select,
    output logic [5:0]  ctl_buf_n,
    output logic [5:0]  ctl_buf_p,
    output logic        seq_irq
);

    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_inj;
    logic [31:0] r_dly;
    logic [31:0] r_cfg0;
    logic [31:0] r_cfg1;
    logic [31:0] r_pi;
    logic [31:0] r_test;
    logic        r_wr_blocked;

    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic [7:0]  w_off;
    logic        w_cfg_ok;
    logic        w_cfg_target;
    logic        w_start;
    logic        w_abort;
    logic        w_blk_set;
    logic        w_blk_clr;
    logic [31:0] w_rd_mux;
    seq_state_e  w_state;

    assign w_hit = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Accept only while ack is low so every access takes exactly two cycles.
    assign w_acc = w_hit && !r_ack;
    assign w_wr  = w_acc && wbs_we_i;
    assign w_off = wbs_adr_i[7:0];

    assign w_cfg_ok     = (w_state == ST_IDLE) || (w_state == ST_RUN);
    assign w_cfg_target = (w_off == C_OFF_CFG0) || (w_off == C_OFF_CFG1) ||
                          (w_off == C_OFF_PI)   || (w_off == C_OFF_TEST);

    assign w_start   = w_wr && (w_off == C_OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[C_CTRL_START_BIT];
    assign w_abort   = w_wr && (w_off == C_OFF_CTRL) && wbs_sel_i[0] && wbs_dat_i[C_CTRL_ABORT_BIT];
    assign w_blk_set = w_wr && w_cfg_target && !w_cfg_ok;
    assign w_blk_clr = w_wr && (w_off == C_OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[C_STATUS_BLK_BIT];

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_off)
            C_OFF_CTRL:   w_rd_mux = {29'h0, r_inj, 2'b00};
            C_OFF_STATUS: w_rd_mux = {27'h0, r_wr_blocked, (w_state == ST_RUN), w_state};
            C_OFF_DLY:    w_rd_mux = r_dly;
            C_OFF_CFG0:   w_rd_mux = r_cfg0;
            C_OFF_CFG1:   w_rd_mux = r_cfg1;
            C_OFF_PI:     w_rd_mux = r_pi;
            C_OFF_TEST:   w_rd_mux = r_test;
            default:      w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ack        <= 1'b0;
            r_rdata      <= 32'h0;
            r_inj        <= 1'b0;
            r_dly        <= {16'h0, DLY_DEFAULT};
            r_cfg0       <= 32'h0;
            r_cfg1       <= 32'h0;
            r_pi         <= 32'h0;
            r_test       <= 32'h0;
            r_wr_blocked <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= w_acc ? w_rd_mux : 32'h0;
            if (w_wr) begin
                case (w_off)
                    C_OFF_CTRL: begin
                        if (wbs_sel_i[0]) r_inj <= wbs_dat_i[C_CTRL_INJ_BIT];
                    end
                    C_OFF_DLY:  r_dly <= apply_be(r_dly, wbs_dat_i, wbs_sel_i, C_MASK_DLY);
                    C_OFF_CFG0: begin
                        if (w_cfg_ok) r_cfg0 <= apply_be(r_cfg0, wbs_dat_i, wbs_sel_i, C_MASK_CFG0);
                    end
                    C_OFF_CFG1: begin
                        if (w_cfg_ok) r_cfg1 <= apply_be(r_cfg1, wbs_dat_i, wbs_sel_i, C_MASK_CFG1);
                    end
                    C_OFF_PI: begin
                        if (w_cfg_ok) r_pi <= apply_be(r_pi, wbs_dat_i, wbs_sel_i, C_MASK_PI);
                    end
                    C_OFF_TEST: begin
                        if (w_cfg_ok) r_test <= apply_be(r_test, wbs_dat_i, wbs_sel_i, C_MASK_TEST);
                    end
                    default: begin
                    end
                endcase
            end
            // A fresh block event wins over a clear landing in the same cycle.
            if (w_blk_set) begin
                r_wr_blocked <= 1'b1;
            end else if (w_blk_clr) begin
                r_wr_blocked <= 1'b0;
            end
        end
    end

    serdes_seq_fsm u_seq_fsm (
        .clk          (wb_clk_i),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_abort      (w_abort),
        .i_dly        (r_dly[15:0]),
        .o_state      (w_state),
        .o_core_rst   (core_rst),
        .o_rst_prbs   (rst_prbs),
        .o_osc_en     (osc_en),
        .o_aux_osc_en (aux_osc_en),
        .o_inj_en     (inj_en),
        .o_fftl_en    (fftl_en),
        .o_seq_irq    (seq_irq)
    );

    assign wbs_ack_o          = r_ack;
    assign wbs_dat_o          = r_rdata;
    assign inj_error          = r_inj;
    assign div_ratio_half     = r_cfg0[C_CFG0_DIV_LSB  +: C_CFG0_DIV_W];
    assign avg_window         = r_cfg0[C_CFG0_AVG_LSB  +: C_CFG0_AVG_W];
    assign step_size          = r_cfg0[C_CFG0_STEP_LSB +: C_CFG0_STEP_W];
    assign con_perb           = r_cfg0[C_CFG0_PERB_LSB +: C_CFG0_PERB_W];
    assign manual_control_osc = r_cfg1[12:0];
    assign pi_con             = r_pi[19:0];
    assign test_mux_select    = r_test[C_TEST_MUX_LSB  +: C_TEST_MUX_W];
    assign clk_I_select       = r_test[C_TEST_CLKI_LSB +: C_TEST_CLKI_W];
    assign clk_Q_select       = r_test[C_TEST_CLKQ_LSB +: C_TEST_CLKQ_W];
    assign ctl_buf_n          = r_test[C_TEST_BUFN_LSB +: C_TEST_BUFN_W];
    assign ctl_buf_p          = r_test[C_TEST_BUFP_LSB +: C_TEST_BUFP_W];

endmodule
`default_nettype wire

// File: tb/tb_serdes_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_cfg_sequencer
// Description : Self-checking bench for serdes_cfg_sequencer with a read-data
//               scoreboard queue and per-cycle sequencer output checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_cfg_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        core_rst, rst_prbs, osc_en, aux_osc_en, inj_en, fftl_en, inj_error, seq_irq;
    logic [5:0]  div_ratio_half, ctl_buf_n, ctl_buf_p;
    logic [4:0]  avg_window;
    logic [3:0]  step_size, con_perb, test_mux_select;
    logic [12:0] manual_control_osc;
    logic [19:0] pi_con;
    logic [1:0]  clk_I_select, clk_Q_select;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    serdes_cfg_sequencer #(.BASE_ADDR(BASE), .DLY_DEFAULT(16'd1024)) dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .core_rst(core_rst), .rst_prbs(rst_prbs), .osc_en(osc_en), .aux_osc_en(aux_osc_en),
        .inj_en(inj_en), .fftl_en(fftl_en), .inj_error(inj_error),
        .div_ratio_half(div_ratio_half), .avg_window(avg_window), .step_size(step_size),
        .con_perb(con_perb), .manual_control_osc(manual_control_osc), .pi_con(pi_con),
        .test_mux_select(test_mux_select), .clk_I_select(clk_I_select), .clk_Q_select(clk_Q_select),
        .ctl_buf_n(ctl_buf_n), .ctl_buf_p(ctl_buf_p), .seq_irq(seq_irq)
    );

    // {core_rst, osc_en, aux_osc_en, inj_en, fftl_en, rst_prbs, seq_irq}
    function automatic logic [6:0] exp_vec(input int st, input bit irq);
        return {st <= 1, st >= 2, st >= 3, st >= 4, st >= 5, st != 6, irq};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {core_rst, osc_en, aux_osc_en, inj_en, fftl_en, rst_prbs, seq_irq};
    endfunction

    // One Wishbone access; returns after the ack cycle has been sampled.
    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        bit got = 0;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        rd = 32'hDEAD_BEEF;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                rd = rdat;
                got = 1;
            end
        end
        stb = 0; cyc = 0; we = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL wb_timeout addr=%h no ack within 16 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_cycle(1'b1, BASE + off, d, s, dummy);
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
        wb_cycle(1'b0, BASE + off, 32'h0, 4'hF, rd);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        logic [31:0] offs [0:2];
        offs[0] = 32'h08; offs[1] = 32'h04; offs[2] = 32'h00;
        #12;
        checks++;
        if (obs_vec() !== exp_vec(0, 0) || ack !== 1'b0 || rdat !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b ack=%b dat=%h exp=%b", obs_vec(), ack, rdat, exp_vec(0, 0));
        end
        rst_n = 1;
        exp_q.push_back(32'h400); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            wb_read(offs[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_read off=%h got=%h exp=%h", offs[i], got, e);
            end
        end
    endtask

    task automatic run_sequence(input int dly, input string nm);
        int irqs = 0;
        int st;
        logic [31:0] got, e;
        wb_write(32'h08, dly, 4'hF);
        exp_q.push_back(dly);
        wb_read(32'h08, got);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_dly_read got=%h exp=%h", nm, got, e);
        end
        wb_write(32'h00, 32'h1, 4'h1);
        for (int k = 0; k < 6 * (dly < 1 ? 1 : dly) + 3; k++) begin
            st = k / (dly < 1 ? 1 : dly) + 1;
            if (st > 6) st = 6;
            checks++;
            if (obs_vec() !== exp_vec(st, k == 5 * (dly < 1 ? 1 : dly))) begin
                errors++;
                $display("FAIL %s_step k=%0d got=%b exp=%b", nm, k, obs_vec(), exp_vec(st, k == 5 * (dly < 1 ? 1 : dly)));
            end
            if (seq_irq) irqs++;
            wait_cycles(1);
        end
        checks++;
        if (irqs != 1) begin
            errors++;
            $display("FAIL %s_irq_count got=%0d exp=1", nm, irqs);
        end
    endtask

    task automatic test_write_block();
        logic [31:0] got, e;
        wb_write(32'h08, 32'd100, 4'hF);
        wb_write(32'h00, 32'h1, 4'h1);
        wait_cycles(110);
        wb_write(32'h0C, 32'h7FFFF, 4'hF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h12);
        wb_read(32'h0C, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL blocked_cfg0 got=%h exp=%h", got, e); end
        wb_read(32'h04, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL blocked_status got=%h exp=%h", got, e); end
        wb_write(32'h04, 32'h10, 4'h1);
        exp_q.push_back(32'h02);
        wb_read(32'h04, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL w1c_status got=%h exp=%h", got, e); end
        wb_write(32'h00, 32'h2, 4'h1);
        wb_write(32'h08, 32'd0, 4'hF);
        wb_write(32'h00, 32'h1, 4'h1);
        wait_cycles(8);
        wb_write(32'h0C, 32'h7FFFF, 4'hF);
        exp_q.push_back(32'h7FFFF); exp_q.push_back(32'h0E);
        wb_read(32'h0C, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL run_cfg0 got=%h exp=%h", got, e); end
        wb_read(32'h04, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL run_status got=%h exp=%h", got, e); end
        checks++;
        if ({con_perb, step_size, avg_window, div_ratio_half} !== {4'hF, 4'hF, 5'h1F, 6'h3F}) begin
            errors++;
            $display("FAIL cfg0_fields got=%h exp=%h", {con_perb, step_size, avg_window, div_ratio_half}, {4'hF, 4'hF, 5'h1F, 6'h3F});
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] got, e;
        wb_write(32'h18, 32'h000C_00A5, 4'hF);
        wb_write(32'h18, 32'h0000_3F00, 4'b0010);
        wb_write(32'h14, 32'hFFF1_2345, 4'hF);
        wb_write(32'h10, 32'hFFFF_1ABC, 4'hF);
        checks++;
        if ({ctl_buf_p, ctl_buf_n, clk_Q_select, clk_I_select, test_mux_select} !== {6'h30, 6'h3F, 2'd2, 2'd2, 4'h5}) begin
            errors++;
            $display("FAIL test_fields got=%h exp=%h", {ctl_buf_p, ctl_buf_n, clk_Q_select, clk_I_select, test_mux_select},
                     {6'h30, 6'h3F, 2'd2, 2'd2, 4'h5});
        end
        checks++;
        if (pi_con !== 20'h12345 || manual_control_osc !== 13'h1ABC) begin
            errors++;
            $display("FAIL pi_cfg1 got=%h/%h exp=12345/1abc", pi_con, manual_control_osc);
        end
        exp_q.push_back(32'h000C_3FA5);
        wb_read(32'h18, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL test_read got=%h exp=%h", got, e); end
    endtask

    task automatic test_ctrl_decode();
        logic [31:0] got, e;
        int acks = 0;
        wb_write(32'h00, 32'h4, 4'h1);
        wb_write(32'h20, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(32'h4); exp_q.push_back(32'h0);
        wb_read(32'h00, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e || inj_error !== 1'b1) begin
            errors++; $display("FAIL ctrl_read got=%h inj=%b exp=%h", got, inj_error, e);
        end
        wb_read(32'h1C, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", got, e); end
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h100; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 0; cyc = 0;
        checks++;
        if (acks != 0) begin errors++; $display("FAIL out_of_range_ack got=%0d exp=0", acks); end
    endtask

    task automatic test_abort();
        logic [31:0] got, e;
        wb_write(32'h08, 32'd3, 4'hF);
        wb_write(32'h00, 32'h1, 4'h1);
        wait_cycles(9);
        checks++;
        if (obs_vec() !== exp_vec(4, 0)) begin
            errors++; $display("FAIL pre_abort got=%b exp=%b", obs_vec(), exp_vec(4, 0));
        end
        wb_write(32'h00, 32'h3, 4'h1);
        checks++;
        if (obs_vec() !== exp_vec(0, 0)) begin
            errors++; $display("FAIL abort_idle got=%b exp=%b", obs_vec(), exp_vec(0, 0));
        end
        exp_q.push_back(32'h0);
        wb_read(32'h04, got);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL abort_status got=%h exp=%h", got, e); end
    endtask

    task automatic test_async_reset();
        logic [31:0] got, e;
        logic [31:0] offs [0:2];
        offs[0] = 32'h08; offs[1] = 32'h0C; offs[2] = 32'h00;
        wb_write(32'h00, 32'h1, 4'h1);
        wait_cycles(7);
        #2 rst_n = 0;
        #1;
        checks++;
        if (obs_vec() !== exp_vec(0, 0) || div_ratio_half !== 6'h0 || inj_error !== 1'b0 || ctl_buf_n !== 6'h0) begin
            errors++;
            $display("FAIL async_reset got=%b div=%h inj=%b bufn=%h exp=%b", obs_vec(), div_ratio_half, inj_error, ctl_buf_n, exp_vec(0, 0));
        end
        #3 rst_n = 1;
        exp_q.push_back(32'h400); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) begin
            wb_read(offs[i], got);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL post_reset_read off=%h got=%h exp=%h", offs[i], got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        run_sequence(3, "dly3");
        run_sequence(0, "dly0");
        test_write_block();
        test_byte_lane();
        test_ctrl_decode();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
